// File: rtl/fir_poly_tx.sv
// fir_poly_tx: polyphase interpolating FIR for the 1-bit BPSK transmit path.
// One symbol is accepted per strobe, and one branch (phase) is emitted per
// enabled clock. The output is saturated, and taps that have not yet been
// filled with a symbol are masked so that start-up is well-defined.
// Optional feature macro: FIR_COEF_LOAD_EN (coefficient bank held in
// registers that can be written at run time).
module fir_poly_tx #(
   parameter int LOG2_OS  = 2,
   parameter int NSYM     = 6,
   parameter int NB_COEF  = 8,
   parameter int NBF_COEF = 7,
   parameter int NB_OUT   = 8,
   parameter int NBF_OUT  = 7,
   // Raised-cosine (beta 0.5) table, c[i] at bits [i*NB_COEF +: NB_COEF],
   // i = k*OS + p; the peak (127) sits at i = 12.
   parameter logic [NSYM*(2**LOG2_OS)*NB_COEF-1:0] COEF_INIT =
      192'h01_02_03_00_F9_F1_F0_00_21_4C_71_7F_71_4C_21_00_F0_F1_F9_00_03_02_01_00
) (
   input  logic                                   clock,
   input  logic                                   i_reset,
   input  logic                                   i_enable,
   input  logic                                   i_data,
   input  logic                                   i_valid,
`ifdef FIR_COEF_LOAD_EN
   input  logic                                   i_coef_we,
   input  logic [$clog2(NSYM*(2**LOG2_OS))-1:0]   i_coef_addr,
   input  logic signed [NB_COEF-1:0]              i_coef_data,
`endif
   output logic signed [NB_OUT-1:0]               o_data,
   output logic                                   o_valid,
   output logic [LOG2_OS-1:0]                     o_phase
);

   localparam int OS    = 2**LOG2_OS;
   localparam int NCOEF = NSYM*OS;
   localparam int CA_W  = $clog2(NCOEF);
   // One spare bit so negating the most negative coefficient cannot wrap.
   localparam int ACC_W = NB_COEF + $clog2(NSYM) + 1;
   localparam int SHIFT = NBF_COEF - NBF_OUT;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(NB_OUT-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(NB_OUT-1)));

   logic        [NSYM-1:0]     sym_q;
   logic        [NSYM-1:0]     fill_q;
   logic        [LOG2_OS-1:0]  ph_q;

   logic signed [NB_OUT-1:0]   data_q;
   logic                       valid_q;
   logic        [LOG2_OS-1:0]  phase_q;

   logic signed [NB_COEF-1:0]  coef [NCOEF];

   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    term;
   logic signed [ACC_W-1:0]    scaled;
   logic        [CA_W-1:0]     cidx;
   logic signed [NB_OUT-1:0]   data_d;

`ifdef FIR_COEF_LOAD_EN
   // Coefficient bank: reset reloads the initial table; writes ignore enable.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < NCOEF; i++) begin
            coef[i] <= COEF_INIT[i*NB_COEF +: NB_COEF];
         end
      end else if (i_coef_we && (32'(i_coef_addr) < NCOEF)) begin
         coef[i_coef_addr] <= i_coef_data;
      end
   end
`else
   // Coefficient bank: fixed constants unpacked from the initial table.
   always_comb begin
      for (int unsigned i = 0; i < NCOEF; i++) begin
         coef[i] = COEF_INIT[i*NB_COEF +: NB_COEF];
      end
   end
`endif

   // Branch sum for the current phase, then scaling and saturation.
   always_comb begin
      acc  = '0;
      term = '0;
      cidx = '0;
      for (int unsigned k = 0; k < NSYM; k++) begin
         cidx = CA_W'(k*OS) + CA_W'(ph_q);
         term = {{(ACC_W-NB_COEF){coef[cidx][NB_COEF-1]}}, coef[cidx]};
         if (fill_q[k]) begin
            acc = sym_q[k] ? (acc - term) : (acc + term);
         end
      end
      scaled = acc >>> SHIFT;
      if (scaled > SAT_HI) begin
         data_d = SAT_HI[NB_OUT-1:0];
      end else if (scaled < SAT_LO) begin
         data_d = SAT_LO[NB_OUT-1:0];
      end else begin
         data_d = scaled[NB_OUT-1:0];
      end
   end

   // Symbol/fill shift, phase counter resync, and registered outputs.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         sym_q   <= '0;
         fill_q  <= '0;
         ph_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         phase_q <= '0;
      end else if (i_enable) begin
         if (i_valid) begin
            sym_q  <= {sym_q[NSYM-2:0], i_data};
            fill_q <= {fill_q[NSYM-2:0], 1'b1};
            ph_q   <= '0;
         end else begin
            ph_q   <= ph_q + 1'b1;
         end
         data_q  <= data_d;
         valid_q <= |fill_q;
         phase_q <= ph_q;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_phase = phase_q;

endmodule

// File: doc/fir_poly_tx.md
# fir_poly_tx

Parametrised polyphase interpolating FIR for the 1-bit symbol transmit path, successor to the fixed 6-coefficient filter. It takes one BPSK symbol per `OS` clocks and emits one filtered sample every enabled clock, one polyphase branch per cycle. Its internal phase counter resyncs to the symbol strobe from the `control` block, and it reports the current phase. It sits between the bit source and the DAC/serialiser, with saturating output and tap-fill masking so start-up transients are well-defined.

## Interface
- `LOG2_OS`, 2: log2 of the oversampling factor; `OS = 2**LOG2_OS`.
- `NSYM`, 6: symbol taps per phase; total coefficients `NSYM*OS`.
- `NB_COEF`, 8: coefficient width, signed, `NBF_COEF` fractional bits.
- `NBF_COEF`, 7: coefficient fractional bits.
- `NB_OUT`, 8: output width, signed, `NBF_OUT` fractional bits.
- `NBF_OUT`, 7: output fractional bits, `NBF_OUT <= NBF_COEF`.
- `COEF_INIT`, raised-cosine table: packed `NSYM*OS*NB_COEF`; entry `c[i]` at bits `[i*NB_COEF +: NB_COEF]`, `i = k*OS + p`.
- `clock`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  1 = run; 0 = freeze all state and outputs.
- `i_data`  in  1  symbol bit; 0 → +1, 1 → −1.
- `i_valid`  in  1  symbol strobe; accepted when `i_valid && i_enable`.
- `i_coef_we`  in  1  coefficient write strobe (only with `FIR_COEF_LOAD_EN`).
- `i_coef_addr`  in  `$clog2(NSYM*OS)`  coefficient index `i` (only with macro).
- `i_coef_data`  in  `NB_COEF`  coefficient value (only with macro).
- `o_data`  out  `NB_OUT`  filtered sample, signed.
- `o_valid`  out  1  `o_data` holds a new sample this cycle.
- `o_phase`  out  `LOG2_OS`  phase index `p` that produced `o_data`.

## Operation
- State: symbol shift register `sym[0..NSYM-1]`; fill mask `fill[0..NSYM-1]`; phase counter `ph`; output registers.
- `sym[0]` is the newest symbol.
- On an accepted symbol: shift `sym`, load `i_data` into `sym[0]`; shift `fill`, load 1 into `fill[0]`; set `ph` to 0.
- Otherwise, when `i_enable`: `ph` ← `ph+1` mod `OS`, wrapping `OS-1 → 0`. `sym` is held, so a missing strobe repeats the branches on the old symbols.
- An early strobe (before `ph` reaches `OS-1`) restarts at phase 0; no phases are skipped-compensated.
- Branch sum: `acc = Σ_k fill[k] ? (sym[k] ? −c[k*OS+ph] : +c[k*OS+ph]) : 0`.
- `acc` width is `NB_COEF + $clog2(NSYM) + 1`; negation of the most negative coefficient must not overflow.
- Scaling: arithmetic right shift by `NBF_COEF − NBF_OUT` (truncate toward −∞).
- Saturation: clamp to [`−2^(NB_OUT−1)`, `2^(NB_OUT−1)−1`].
- `o_valid` = `i_enable` && any `fill` bit set, registered alongside `o_data`.
- With `i_enable` = 0: the `i_valid` strobe is ignored; `o_data`, `o_phase` and internal state hold; `o_valid` = 0.

## Timing
- Reset values: `sym`, `fill`, `ph` = 0; `o_data` = 0; `o_valid` = 0; `o_phase` = 0.
- Reset has priority over enable and over a coefficient write.
- Reset mid-stream discards all symbols; the next accepted symbol begins a fresh fill.
- Symbol accepted at edge N: phase p of that symbol appears on `o_data`/`o_phase` after edge N+1+p.
- Latency from strobe to phase-0 output is 2 edges.
- Output rate is one sample per enabled clock.

## Configuration
- `FIR_COEF_LOAD_EN` defined:
  - coefficients are registers, loaded from `COEF_INIT` on reset;
  - `i_coef_we` writes `c[i_coef_addr]` at the edge, independent of `i_enable`, and is used by the branch sum from the next cycle;
  - an out-of-range address is ignored.
- Not defined: coefficients are constants from `COEF_INIT`, and the three coefficient ports are absent.

## Test plan
All scenarios use `LOG2_OS`=2, `NSYM`=6, `NB_OUT`=`NB_COEF`=8, `NBF_OUT`=`NBF_COEF`=7, with the strobe from `control` every 4 clocks.
- Reset/fill: all `c`=16, six `i_data`=0 symbols:
  - `o_data` steps 16, 32, 48, 64, 80, 96, each held for 4 samples;
  - `o_valid` rises 2 edges after the first strobe;
  - `o_phase` cycles 0,1,2,3.
- Sign mapping: all `c`=16, steady state, alternating 0/1 symbols → `o_data` = 0 on every sample.
- Saturation: all `c`=64, six 0s → 127; then six 1s → −128 (raw ±384).
- Enable/strobe: deassert `i_enable` for 7 cycles with strobes pulsed → `o_data`/`o_phase` frozen, `o_valid`=0, no symbol accepted; resume continues at the frozen phase+1.
- Early strobe and reset: a strobe at phase 1 gives next `o_phase` 0. Reset asserted mid-symbol gives all outputs 0 next cycle; refill restarts at 16.
- `FIR_COEF_LOAD_EN`: all `c`=16 after six 0s; write `c[0]`=48 → phase-0 samples become 128 saturated to 127, other phases stay 96.
